// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the clocked hazard scoreboard: forwarding select
// encodings, Tuse/Tnew constants and the per-stage shadow record.
package hazard_scoreboard_pkg;

   localparam int REG_W  = 5;
   localparam int TIME_W = 2;

   // D-stage forwarding selects
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_E  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b11;

   // E-stage forwarding selects
   localparam logic [1:0] FWDE_PIPE = 2'b00;
   localparam logic [1:0] FWDE_M    = 2'b01;
   localparam logic [1:0] FWDE_W    = 2'b10;

   localparam logic [TIME_W-1:0] T_BRANCH  = 2'd0;
   localparam logic [TIME_W-1:0] T_ALU     = 2'd1;
   localparam logic [TIME_W-1:0] T_STORE   = 2'd2;
   localparam logic [TIME_W-1:0] TNEW_LOAD = 2'd2;
   localparam logic [TIME_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [TIME_W-1:0] TNEW_LINK = 2'd0;

   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [TIME_W-1:0] tnew;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic              md;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '{dst: {REG_W{1'b0}}, tnew: {TIME_W{1'b0}},
                                       rs: {REG_W{1'b0}}, rt: {REG_W{1'b0}}, md: 1'b0};

   // One pipeline step closer to producing the result, saturating at zero.
   function automatic logic [TIME_W-1:0] tnew_age(input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0] r;
      if (t == {TIME_W{1'b0}}) r = {TIME_W{1'b0}};
      else                     r = t - {{(TIME_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy.sv
// HI/LO unit busy tracker: notes a mult/div entering E and counts down its latency.
module hazard_md_busy
   import hazard_scoreboard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic issue,
   input  logic issue_div,
   output logic md_busy
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             md_in_e_r;
   logic             div_e_r;
   logic [CNT_W-1:0] cnt_r;

   // E-stage md flag and the latency counter it loads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         md_in_e_r <= 1'b0;
         div_e_r   <= 1'b0;
         cnt_r     <= CNT_ZERO;
      end else begin
         md_in_e_r <= issue;
         div_e_r   <= issue & issue_div;
         if (md_in_e_r)             cnt_r <= div_e_r ? DIV_LOAD : MULT_LOAD;
         else if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
         else                        cnt_r <= cnt_r;
      end
   end

   assign md_busy = md_in_e_r | (cnt_r != CNT_ZERO);

endmodule

// File: rtl/hazard_scoreboard.sv
// Clocked hazard unit for the 5-stage MIPS core: shadows E/M/W destinations and
// Tnew, and derives stall and forwarding selects from Tuse/Tnew comparison.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int RA_W        = REG_W,
   parameter int T_W         = TIME_W,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [RA_W-1:0] rs_d,
   input  logic [RA_W-1:0] rt_d,
   input  logic [T_W-1:0]  tuse_rs_d,
   input  logic [T_W-1:0]  tuse_rt_d,
   input  logic            use_rs_d,
   input  logic            use_rt_d,
   input  logic [RA_W-1:0] dst_d,
   input  logic [T_W-1:0]  tnew_e_d,
   input  logic            md_op_d,
   input  logic            md_start_d,
   input  logic            md_div_d,
   output logic            stall,
   output logic [1:0]      fwd_rs_d,
   output logic [1:0]      fwd_rt_d,
   output logic [1:0]      fwd_rs_e,
   output logic [1:0]      fwd_rt_e,
   output logic            fwd_rt_m,
   output logic            md_busy
);

   localparam logic [RA_W-1:0] R0 = {RA_W{1'b0}};
   localparam logic [T_W-1:0]  T0 = {T_W{1'b0}};

   stage_t e_r, m_r, w_r, e_next_s;
   logic   haz_rs_s, haz_rt_s, stall_s, md_issue_s;
   logic   unused_s;

   // The youngest matching producer decides; an older match behind it is ignored.
   function automatic logic src_hazard(input logic [RA_W-1:0] r, input logic used,
                                       input logic [T_W-1:0] tuse, input stage_t e, input stage_t m);
      logic h;
      h = 1'b0;
      if (!used || r == R0)  h = 1'b0;
      else if (e.dst == r)   h = (e.tnew > tuse);
      else if (m.dst == r)   h = (m.tnew > tuse);
      else                   h = 1'b0;
      return h;
   endfunction

   function automatic logic [1:0] d_select(input logic [RA_W-1:0] r, input stage_t e,
                                           input stage_t m, input stage_t w);
      logic [1:0] f;
      f = FWD_RF;
      if (r == R0)         f = FWD_RF;
      else if (e.dst == r) f = (e.tnew == T0) ? FWD_E : FWD_RF;
      else if (m.dst == r) f = (m.tnew == T0) ? FWD_M : FWD_RF;
      else if (w.dst == r) f = (w.tnew == T0) ? FWD_W : FWD_RF;
      else                 f = FWD_RF;
      return f;
   endfunction

   function automatic logic [1:0] e_select(input logic [RA_W-1:0] r, input stage_t m, input stage_t w);
      logic [1:0] f;
      f = FWDE_PIPE;
      if (r == R0)         f = FWDE_PIPE;
      else if (m.dst == r) f = (m.tnew == T0) ? FWDE_M : FWDE_PIPE;
      else if (w.dst == r) f = (w.tnew == T0) ? FWDE_W : FWDE_PIPE;
      else                 f = FWDE_PIPE;
      return f;
   endfunction

   // Stall and forwarding selects, valid in the same cycle as the D inputs
   always_comb begin
      haz_rs_s = src_hazard(rs_d, use_rs_d, tuse_rs_d, e_r, m_r);
      haz_rt_s = src_hazard(rt_d, use_rt_d, tuse_rt_d, e_r, m_r);
      stall_s  = haz_rs_s | haz_rt_s | (md_op_d & md_busy);
      fwd_rs_d = d_select(rs_d, e_r, m_r, w_r);
      fwd_rt_d = d_select(rt_d, e_r, m_r, w_r);
      fwd_rs_e = e_select(e_r.rs, m_r, w_r);
      fwd_rt_e = e_select(e_r.rt, m_r, w_r);
      fwd_rt_m = (m_r.rt != R0) && (w_r.dst == m_r.rt);
   end

   assign stall      = stall_s;
   assign md_issue_s = md_start_d & ~stall_s;

   // Record entering E: the D instruction, or a bubble while stalled
   always_comb begin
      e_next_s = STAGE_BUBBLE;
      if (!stall_s) begin
         e_next_s.dst  = dst_d;
         e_next_s.tnew = tnew_e_d;
         e_next_s.rs   = use_rs_d ? rs_d : R0;
         e_next_s.rt   = use_rt_d ? rt_d : R0;
         e_next_s.md   = md_start_d;
      end else begin
         e_next_s = STAGE_BUBBLE;
      end
   end

   // Shadow pipeline E -> M -> W; Tnew ages by one per stage and is zero in W
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_r <= STAGE_BUBBLE;
         m_r <= STAGE_BUBBLE;
         w_r <= STAGE_BUBBLE;
      end else begin
         e_r <= e_next_s;
         m_r <= '{dst: e_r.dst, tnew: tnew_age(e_r.tnew), rs: e_r.rs, rt: e_r.rt, md: e_r.md};
         w_r <= '{dst: m_r.dst, tnew: T0, rs: m_r.rs, rt: m_r.rt, md: m_r.md};
      end
   end

   // Record fields carried for completeness but not consumed by any select
   assign unused_s = ^{e_r.md, m_r.rs, m_r.md, w_r.rs, w_r.rt, w_r.md};

   hazard_md_busy #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_busy (
      .clk      (clk),
      .reset_n  (reset_n),
      .issue    (md_issue_s),
      .issue_div(md_div_d),
      .md_busy  (md_busy)
   );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a driver predicts each cycle's outputs from an instruction
// history model and queues them; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
   localparam int MAXC   = 8192;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] rs_d = 5'd0, rt_d = 5'd0, dst_d = 5'd0;
   logic [1:0] tuse_rs_d = 2'd0, tuse_rt_d = 2'd0, tnew_e_d = 2'd0;
   logic       use_rs_d = 1'b0, use_rt_d = 1'b0, md_op_d = 1'b0, md_start_d = 1'b0, md_div_d = 1'b0;
   logic       stall, fwd_rt_m, md_busy;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

   always #5 clk = ~clk;

   hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d),
      .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
      .dst_d(dst_d), .tnew_e_d(tnew_e_d), .md_op_d(md_op_d), .md_start_d(md_start_d),
      .md_div_d(md_div_d), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
      .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy));

   // hist[k] is the instruction that left D in cycle k (bubble if it stalled);
   // it sits in E during cycle k+1, M during k+2 and W during k+3.
   typedef struct { int dst; int tnew; int rs; int rt; bit md; } ins_t;
   typedef struct { int cyc; int stall; int frsd; int frtd; int frse; int frte; int frtm; int busy; } exp_t;

   ins_t hist[MAXC];
   exp_t q[$];
   exp_t x;
   int   cyc = 0, base = 0, busy_until = -1;
   int   total = 0, passed = 0;
   int   ns;

   task automatic chk(input string name, input int c, input int act, input int exp_v);
      total++;
      if (act == exp_v) passed++;
      else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, c, act, exp_v);
   endtask

   function automatic ins_t at(input int k);
      ins_t b;
      b = '{dst: 0, tnew: 0, rs: 0, rt: 0, md: 1'b0};
      if (k < base || k < 0) return b;
      return hist[k];
   endfunction

   // Cycles still needed before the value exists; nothing is pending once in W.
   function automatic int remaining(input ins_t i, input int age);
      int r;
      r = i.tnew - age;
      if (age >= 2 || r < 0) r = 0;
      return r;
   endfunction

   function automatic int hazard(input int r, input bit u, input int tuse);
      ins_t i;
      if (!u || r == 0) return 0;
      for (int a = 0; a < 2; a++) begin
         i = at(cyc - 1 - a);
         if (i.dst == r) return (remaining(i, a) > tuse) ? 1 : 0;
      end
      return 0;
   endfunction

   function automatic int sel_d(input int r);
      ins_t i;
      if (r == 0) return 0;
      for (int a = 0; a < 3; a++) begin
         i = at(cyc - 1 - a);
         if (i.dst == r) return (remaining(i, a) == 0) ? a + 1 : 0;
      end
      return 0;
   endfunction

   function automatic int sel_e(input int r);
      ins_t i;
      if (r == 0) return 0;
      for (int a = 1; a < 3; a++) begin
         i = at(cyc - 1 - a);
         if (i.dst == r) return (remaining(i, a) == 0) ? a : 0;
      end
      return 0;
   endfunction

   task automatic step(input int rs, input int rt, input int trs, input int trt,
                       input bit urs, input bit urt, input int dst, input int tnew,
                       input bit mop, input bit mst, input bit mdiv,
                       output bit st_model, output bit st_dut);
      exp_t e;
      ins_t m, w;
      int   busy, st;
      @(posedge clk); #1;
      rs_d = 5'(rs); rt_d = 5'(rt); tuse_rs_d = 2'(trs); tuse_rt_d = 2'(trt);
      use_rs_d = urs; use_rt_d = urt; dst_d = 5'(dst); tnew_e_d = 2'(tnew);
      md_op_d = mop; md_start_d = mst; md_div_d = mdiv;
      busy = (cyc <= busy_until) ? 1 : 0;
      st   = (hazard(rs, urs, trs) | hazard(rt, urt, trt) | ((mop && busy != 0) ? 1 : 0));
      m = at(cyc - 2);
      w = at(cyc - 3);
      e.cyc = cyc; e.stall = st; e.busy = busy;
      e.frsd = sel_d(rs); e.frtd = sel_d(rt);
      e.frse = sel_e(at(cyc - 1).rs); e.frte = sel_e(at(cyc - 1).rt);
      e.frtm = (m.rt != 0 && w.dst == m.rt) ? 1 : 0;
      q.push_back(e);
      if (st != 0) hist[cyc] = '{dst: 0, tnew: 0, rs: 0, rt: 0, md: 1'b0};
      else begin
         hist[cyc] = '{dst: dst, tnew: tnew, rs: urs ? rs : 0, rt: urt ? rt : 0, md: mst};
         if (mst) busy_until = cyc + 1 + (mdiv ? DIV_N : MULT_N);
      end
      cyc++;
      st_model = (st != 0);
      @(negedge clk); #1;
      st_dut = stall;
   endtask

   // Holds one instruction in D until the model releases it; returns DUT stall cycles.
   task automatic issue(input int rs, input int rt, input int trs, input int trt,
                        input bit urs, input bit urt, input int dst, input int tnew,
                        input bit mop, input bit mst, input bit mdiv, output int nstall);
      bit sm, sd;
      int n;
      n = 0; nstall = 0;
      do begin
         step(rs, rt, trs, trt, urs, urt, dst, tnew, mop, mst, mdiv, sm, sd);
         if (sd) nstall++;
         n++;
      end while (sm && n < 40);
      if (sm) chk("issue_bound", cyc, n, 0);
   endtask

   task automatic nops(input int n);
      int d;
      for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, d);
   endtask

   // Monitor: every predicted cycle is compared against what the DUT shows
   always @(negedge clk) begin
      if (q.size() != 0) begin
         x = q.pop_front();
         chk("stall",    x.cyc, int'(stall),    x.stall);
         chk("fwd_rs_d", x.cyc, int'(fwd_rs_d), x.frsd);
         chk("fwd_rt_d", x.cyc, int'(fwd_rt_d), x.frtd);
         chk("fwd_rs_e", x.cyc, int'(fwd_rs_e), x.frse);
         chk("fwd_rt_e", x.cyc, int'(fwd_rt_e), x.frte);
         chk("fwd_rt_m", x.cyc, int'(fwd_rt_m), x.frtm);
         chk("md_busy",  x.cyc, int'(md_busy),  x.busy);
      end
   end

   initial begin
      // Reset: outputs quiet even with a D instruction that would otherwise hazard
      rs_d = 5'd8; rt_d = 5'd8; use_rs_d = 1'b1; use_rt_d = 1'b1; md_op_d = 1'b1;
      #22;
      chk("rst_stall", 0, int'(stall), 0);
      chk("rst_busy", 0, int'(md_busy), 0);
      chk("rst_fwd", 0, int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
      @(negedge clk);
      rs_d = 5'd0; rt_d = 5'd0; use_rs_d = 1'b0; use_rt_d = 1'b0; md_op_d = 1'b0;
      reset_n = 1'b1;

      // lw $8 ; add $9,$8,$1
      issue(0, 0, 0, 0, 1'b0, 1'b0, 8, 2, 1'b0, 1'b0, 1'b0, ns);
      issue(8, 1, 1, 1, 1'b1, 1'b1, 9, 1, 1'b0, 1'b0, 1'b0, ns);
      chk("lw_add_stalls", cyc, ns, 1);
      nops(3);
      // addu $8 ; beq $8,$0
      issue(0, 0, 0, 0, 1'b0, 1'b0, 8, 1, 1'b0, 1'b0, 1'b0, ns);
      issue(8, 0, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, ns);
      chk("addu_beq_stalls", cyc, ns, 1);
      nops(3);
      // lw $8 ; beq $8
      issue(0, 0, 0, 0, 1'b0, 1'b0, 8, 2, 1'b0, 1'b0, 1'b0, ns);
      issue(8, 0, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, ns);
      chk("lw_beq_stalls", cyc, ns, 2);
      nops(3);
      // jal ; beq $31
      issue(0, 0, 0, 0, 1'b0, 1'b0, 31, 0, 1'b0, 1'b0, 1'b0, ns);
      issue(31, 0, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, ns);
      chk("jal_beq_stalls", cyc, ns, 0);
      nops(3);
      // addu $8 ; sw $8,0($2)
      issue(0, 0, 0, 0, 1'b0, 1'b0, 8, 1, 1'b0, 1'b0, 1'b0, ns);
      issue(2, 8, 1, 2, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, ns);
      chk("addu_sw_stalls", cyc, ns, 0);
      nops(3);
      // lw $0 ; add using $0
      issue(0, 0, 0, 0, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0, ns);
      issue(0, 0, 0, 0, 1'b1, 1'b1, 9, 1, 1'b0, 1'b0, 1'b0, ns);
      chk("zero_reg_stalls", cyc, ns, 0);
      nops(3);
      // mult ; mflo
      issue(4, 5, 1, 1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, ns);
      issue(0, 0, 0, 0, 1'b0, 1'b0, 6, 1, 1'b1, 1'b0, 1'b0, ns);
      chk("mult_mflo_stalls", cyc, ns, MULT_N + 1);
      nops(2);
      // div, then reset in the middle of the count
      issue(4, 5, 1, 1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, ns);
      nops(2);
      @(posedge clk); #2;
      md_op_d = 1'b1; rs_d = 5'd9; use_rs_d = 1'b1;
      chk("pre_rst_busy", cyc, int'(md_busy), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", cyc, int'(md_busy), 0);
      chk("mid_rst_stall", cyc, int'(stall), 0);
      @(negedge clk);
      md_op_d = 1'b0; rs_d = 5'd0; use_rs_d = 1'b0;
      reset_n = 1'b1;
      cyc++; base = cyc; busy_until = -1;

      // Randomised traffic on a small register set to provoke many matches
      for (int k = 0; k < 300; k++) begin
         int r;
         bit mop, mst;
         r = $urandom_range(0, 9);
         mop = (r <= 1); mst = (r == 0);
         issue($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 2), mop, mst, 1'($urandom_range(0, 1)), ns);
      end
      nops(2);
      @(negedge clk); #2;
      chk("queue_drained", cyc, q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
